// File: rtl/jpu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, funct3 codes, and access-size helpers.
package jpu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // Unused funct3 encodings (3/6/7) fall through to a word access.
  function automatic lsu_size_t f3_size(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: f3_size = SZ_BYTE;
      F3_LH, F3_LHU: f3_size = SZ_HALF;
      default:       f3_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (f3_size(funct3))
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: funct3 + address offset to bus byte enables / replicated store data,
// and bus read data to the sign- or zero-extended load value.
module lsu_align
  import jpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b0000;
    lane_wdata = '0;
    load_data  = '0;
    byte_sel   = rdata[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? rdata[31:16] : rdata[15:0];
    case (f3_size(funct3))
      SZ_BYTE: begin
        be         = 4'b0001 << offset;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = (funct3 == F3_LB) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      // Halfword lane is chosen by addr[1] only; addr[0] is ignored here.
      SZ_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = (funct3 == F3_LH) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit on a req/gnt/rvalid bus with a one-cycle writeback response.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses answer with an error, no bus access.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a load/store from execute
//   REQ   | mem_req held with stable address/lanes until mem_gnt
//   WAIT  | load granted, waiting for mem_rvalid or the timeout
//   RESP  | rsp_valid pulse for one cycle
module load_store_unit
  import jpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_we,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  // Timeout fires in the cycle the counter would reach MAX_WAIT, i.e. after MAX_WAIT WAIT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  lsu_state_t state, state_nxt;

  logic             store_q;
  logic [2:0]       funct3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [4:0]       rd_q;
  logic [31:0]      data_q;
  logic             we_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic        accept;
  logic        misalign;
  logic        take_data;
  logic        timeout;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;
  logic [31:0] load_ext;

  lsu_align u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .be         (be_lane),
    .lane_wdata (wdata_lane),
    .load_data  (load_ext)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    state_nxt = state;
    take_data = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (req_valid) state_nxt = misalign ? RESP : REQ;
      REQ: begin
        if (mem_gnt) begin
          if (store_q) begin
            state_nxt = RESP;
          end else if (mem_rvalid) begin
            state_nxt = RESP;
            take_data = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt = RESP;
          take_data = 1'b1;
        end else if ((MAX_WAIT != 0) && (cnt_q == CNT_LAST)) begin
          state_nxt = RESP;
          timeout   = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        data_q   <= '0;
        we_q     <= 1'b0;
        err_q    <= misalign;
      end
      if (take_data) begin
        data_q <= load_ext;
        we_q   <= 1'b1;
      end
      if (timeout) err_q <= 1'b1;
      if (state != WAIT) cnt_q <= '0;
      else if ((MAX_WAIT != 0) && (cnt_q != CNT_LAST)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign req_ready = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req & store_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_lane : '0;
  assign mem_wdata = mem_we ? wdata_lane : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_we    = rsp_valid & we_q;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = rsp_valid ? data_q : '0;
  assign rsp_rd    = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed + randomized bench for load_store_unit against an arithmetic model of lane steering,
// extension, response latency and timeout.
module tb_load_store_unit;

  localparam int unsigned MW = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic        rsp_we;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data;
  int          last_lat;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_we     (rsp_we),
    .rsp_rd     (rsp_rd),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size_of(f3) == 2) return (off % 2) != 0;
    if (size_of(f3) == 4) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size_of(f3) == 1) return 32'(1 << off);
    if (size_of(f3) == 2) return (off >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (size_of(f3) == 1) return (w % 256) * 32'h0101_0101;
    if (size_of(f3) == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int off;
    logic [31:0] v;
    off = int'(addr % 4);
    if (size_of(f3) == 1) begin
      v = (rd >> (8 * off)) % 256;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size_of(f3) == 2) begin
      v = (rd >> ((off >= 2) ? 16 : 0)) % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One transaction. gd = cycles of REQ before gnt; rv = cycles after gnt before rvalid
  // (0 = same cycle as gnt, -1 = never, so the load times out).
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rv,
                     input logic [31:0] rdata);
    int cyc;
    bit got;
    bit trap;
    int exp_lat;
    logic [31:0] ed;
    logic ewe;
    logic eerr;
    trap = TRAP_EN && misaligned(f3, addr);
    if (trap) begin
      exp_lat = 1; ed = 0; ewe = 0; eerr = 1;
    end else if (st) begin
      exp_lat = gd + 2; ed = 0; ewe = 0; eerr = 0;
    end else if (rv < 0) begin
      exp_lat = gd + int'(MW) + 2; ed = 0; ewe = 0; eerr = 1;
    end else begin
      exp_lat = gd + rv + 2; ed = model_load(f3, addr, rdata); ewe = 1; eerr = 0;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      cyc++;
      // Upstream noise while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_store = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = $urandom;
      req_wdata = $urandom;
      req_rd = 5'($urandom_range(0, 31));
      mem_gnt = !trap && (cyc == gd + 1);
      if (!st && !trap && rv >= 0 && cyc == gd + 1 + rv) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end else if (cyc <= gd) begin
        mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      @(negedge clk);
      chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
      if (rsp_valid) begin
        got = 1'b1;
        chk("rsp_latency", cyc, exp_lat);
        chk("rsp_we", {31'b0, rsp_we}, {31'b0, ewe});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, eerr});
        chk("rsp_data", rsp_data, ed);
        chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, rd});
        chk("mem_req_in_resp", {31'b0, mem_req}, 32'd0);
        last_data = rsp_data;
        last_lat = cyc;
      end else if (!trap && cyc <= gd + 1) begin
        chk("mem_req_held", {31'b0, mem_req}, 32'd1);
        chk("mem_we", {31'b0, mem_we}, {31'b0, st});
        chk("mem_addr", mem_addr, addr - (addr % 4));
        chk("mem_be", {28'b0, mem_be}, model_be(f3, addr));
        if (st) chk("mem_wdata", mem_wdata, model_wdata(f3, wd));
      end else begin
        chk("mem_req_dropped", {31'b0, mem_req}, 32'd0);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!got) chk("rsp_never_arrived", 32'd0, 32'd1);
    @(negedge clk);
    chk("rsp_single_pulse", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_after", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic st;
    logic [2:0] f3;
    int gd;
    int rv;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", {27'b0, rsp_rd}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SW, gnt one cycle after req
    run(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd3, 1, 0, 32'h0);
    chk("sw_latency", last_lat, 32'd3);
    // SB to top lane
    run(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 5'd4, 0, 0, 32'h0);
    // LB / LBU at offset 2
    run(1'b0, 3'd0, 32'h202, 32'h0, 5'd5, 0, 1, 32'h0080_FF00);
    chk("lb_value", last_data, 32'hFFFF_FF80);
    run(1'b0, 3'd4, 32'h202, 32'h0, 5'd6, 1, 2, 32'h0080_FF00);
    chk("lbu_value", last_data, 32'h0000_0080);
    // LH with gnt and rvalid in the same cycle: minimum latency
    run(1'b0, 3'd1, 32'h302, 32'h0, 5'd7, 0, 0, 32'h8001_1234);
    chk("lh_value", last_data, 32'hFFFF_8001);
    chk("lh_latency", last_lat, 32'd2);
    // LW timeout
    run(1'b0, 3'd2, 32'h400, 32'h0, 5'd8, 0, -1, 32'h0);
    chk("lw_timeout_lat", last_lat, 32'(MW + 2));
    // LW misaligned
    run(1'b0, 3'd2, 32'h101, 32'h0, 5'd9, 0, 1, 32'h1234_5678);
    if (TRAP_EN) chk("lw_mis_trap_data", last_data, 32'h0);
    else         chk("lw_mis_data", last_data, 32'h1234_5678);

    // Reset pulse while in WAIT
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h500; req_rd = 5'd10;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("wait_mem_req", {31'b0, mem_req}, 32'd0);
    chk("wait_busy", {31'b0, req_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge clk);
      chk("late_rvalid_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("late_rvalid_ready", {31'b0, req_ready}, 32'd1);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      gd = int'($urandom_range(0, 3));
      rv = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      run(st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)), gd, rv, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
